// File: rtl/id_ex_mem_wb_regs.sv
// Pipeline boundary registers for the 16-bit five-stage CPU: ID/EX, EX/MEM and MEM/WB.
// Each bank is a plain register stage; reset loads a NOP bubble (all zeros) into every bank.
module id_ex_mem_wb_regs #(
  parameter int REG_W  = 16,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [OP_W-1:0]   id_aluop,
  input  logic [SEL_W-1:0]  id_alusel,
  input  logic [REG_W-1:0]  id_reg1,
  input  logic [REG_W-1:0]  id_reg2,
  input  logic [ADDR_W-1:0] id_wd,
  input  logic              id_wreg,

  output logic [OP_W-1:0]   ex_aluop,
  output logic [SEL_W-1:0]  ex_alusel,
  output logic [REG_W-1:0]  ex_reg1,
  output logic [REG_W-1:0]  ex_reg2,
  output logic [ADDR_W-1:0] ex_wd,
  output logic              ex_wreg,

  input  logic [ADDR_W-1:0] ex_res_wd,
  input  logic              ex_res_wreg,
  input  logic [REG_W-1:0]  ex_res_wdata,

  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [REG_W-1:0]  mem_wdata,

  input  logic [ADDR_W-1:0] mem_res_wd,
  input  logic              mem_res_wreg,
  input  logic [REG_W-1:0]  mem_res_wdata,

  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [REG_W-1:0]  wb_wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_aluop  <= '0;
      ex_alusel <= '0;
      ex_reg1   <= '0;
      ex_reg2   <= '0;
      ex_wd     <= '0;
      ex_wreg   <= 1'b0;
    end else begin
      ex_aluop  <= id_aluop;
      ex_alusel <= id_alusel;
      ex_reg1   <= id_reg1;
      ex_reg2   <= id_reg2;
      ex_wd     <= id_wd;
      ex_wreg   <= id_wreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_wd    <= ex_res_wd;
      mem_wreg  <= ex_res_wreg;
      mem_wdata <= ex_res_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd    <= '0;
      wb_wreg  <= 1'b0;
      wb_wdata <= '0;
    end else begin
      wb_wd    <= mem_res_wd;
      wb_wreg  <= mem_res_wreg;
      wb_wdata <= mem_res_wdata;
    end
  end

endmodule

// File: tb/tb_id_ex_mem_wb_regs.sv
// Bench for id_ex_mem_wb_regs: directed scenarios plus randomized traffic against a snapshot model.
module tb_id_ex_mem_wb_regs;
  localparam int REG_W  = 16;
  localparam int ADDR_W = 4;
  localparam int OP_W   = 8;
  localparam int SEL_W  = 3;
  localparam logic [OP_W-1:0]  OP_AND    = 8'h24;
  localparam logic [SEL_W-1:0] SEL_LOGIC = 3'b001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [OP_W-1:0]   id_aluop;
  logic [SEL_W-1:0]  id_alusel;
  logic [REG_W-1:0]  id_reg1, id_reg2;
  logic [ADDR_W-1:0] id_wd;
  logic              id_wreg;
  logic [OP_W-1:0]   ex_aluop;
  logic [SEL_W-1:0]  ex_alusel;
  logic [REG_W-1:0]  ex_reg1, ex_reg2;
  logic [ADDR_W-1:0] ex_wd;
  logic              ex_wreg;
  logic [ADDR_W-1:0] ex_res_wd, mem_wd, mem_res_wd, wb_wd;
  logic              ex_res_wreg, mem_wreg, mem_res_wreg, wb_wreg;
  logic [REG_W-1:0]  ex_res_wdata, mem_wdata, mem_res_wdata, wb_wdata;

  // Either the bench drives the stage results directly, or it closes the loop
  // with an AND-only EX model and a pass-through MEM model.
  logic              chain;
  logic [ADDR_W-1:0] drv_ex_wd, drv_mem_wd;
  logic              drv_ex_wreg, drv_mem_wreg;
  logic [REG_W-1:0]  drv_ex_wdata, drv_mem_wdata;

  assign ex_res_wd     = chain ? ex_wd             : drv_ex_wd;
  assign ex_res_wreg   = chain ? ex_wreg           : drv_ex_wreg;
  assign ex_res_wdata  = chain ? (ex_reg1 & ex_reg2) : drv_ex_wdata;
  assign mem_res_wd    = chain ? mem_wd            : drv_mem_wd;
  assign mem_res_wreg  = chain ? mem_wreg          : drv_mem_wreg;
  assign mem_res_wdata = chain ? mem_wdata         : drv_mem_wdata;

  wire [47:0] id_vec     = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
  wire [47:0] ex_vec     = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};
  wire [20:0] exres_vec  = {ex_res_wd, ex_res_wreg, ex_res_wdata};
  wire [20:0] mem_vec    = {mem_wd, mem_wreg, mem_wdata};
  wire [20:0] memres_vec = {mem_res_wd, mem_res_wreg, mem_res_wdata};
  wire [20:0] wb_vec     = {wb_wd, wb_wreg, wb_wdata};

  int tests = 0;
  int fails = 0;

  id_ex_mem_wb_regs #(.REG_W(REG_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_res_wd(ex_res_wd), .ex_res_wreg(ex_res_wreg), .ex_res_wdata(ex_res_wdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_res_wd(mem_res_wd), .mem_res_wreg(mem_res_wreg), .mem_res_wdata(mem_res_wdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_and_vector();
    id_aluop = OP_AND; id_alusel = SEL_LOGIC;
    id_reg1 = 16'h0033; id_reg2 = 16'h000F; id_wd = 4'd2; id_wreg = 1'b1;
  endtask

  task automatic test_reset();
    chain = 1'b0;
    rst = 1'b1;
    id_aluop = '1; id_alusel = '1; id_reg1 = 16'hFFFF; id_reg2 = 16'hFFFF;
    id_wd = '1; id_wreg = 1'b1;
    drv_ex_wd = '1; drv_ex_wreg = 1'b1; drv_ex_wdata = 16'hFFFF;
    drv_mem_wd = '1; drv_mem_wreg = 1'b1; drv_mem_wdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (ex_vec !== 48'd0)  begin fails++; $display("FAIL reset_ex got %h exp 0", ex_vec); end
      tests++; if (mem_vec !== 21'd0) begin fails++; $display("FAIL reset_mem got %h exp 0", mem_vec); end
      tests++; if (wb_vec !== 21'd0)  begin fails++; $display("FAIL reset_wb got %h exp 0", wb_vec); end
    end
  endtask

  task automatic test_latency();
    chain = 1'b0;
    drive_and_vector();
    #3 rst = 1'b0;
    #3;
    tests++; if (ex_vec !== 48'd0) begin fails++; $display("FAIL latency_pre_edge got %h exp 0", ex_vec); end
    tick();
    tests++;
    if (ex_vec !== {OP_AND, SEL_LOGIC, 16'h0033, 16'h000F, 4'd2, 1'b1}) begin
      fails++; $display("FAIL latency_first_edge got %h exp %h", ex_vec,
                        {OP_AND, SEL_LOGIC, 16'h0033, 16'h000F, 4'd2, 1'b1});
    end
  endtask

  task automatic test_chain();
    rst = 1'b1;
    tick();
    chain = 1'b1;
    drive_and_vector();
    #3 rst = 1'b0;
    tick();
    tests++; if (ex_reg1 !== 16'h0033 || ex_reg2 !== 16'h000F) begin
      fails++; $display("FAIL chain_ex got %h/%h exp 0033/000f", ex_reg1, ex_reg2); end
    tests++; if (mem_vec !== 21'd0) begin fails++; $display("FAIL chain_mem_early got %h exp 0", mem_vec); end
    tick();
    tests++; if (mem_vec !== {4'd2, 1'b1, 16'h0003}) begin
      fails++; $display("FAIL chain_mem got %h exp %h", mem_vec, {4'd2, 1'b1, 16'h0003}); end
    tests++; if (wb_vec !== 21'd0) begin fails++; $display("FAIL chain_wb_early got %h exp 0", wb_vec); end
    tick();
    tests++; if (wb_vec !== {4'd2, 1'b1, 16'h0003}) begin
      fails++; $display("FAIL chain_wb got %h exp %h", wb_vec, {4'd2, 1'b1, 16'h0003}); end
  endtask

  task automatic test_async_reset();
    // Banks are full from the chained run; pulse reset between edges.
    #2 rst = 1'b1;
    #1;
    tests++; if (ex_vec !== 48'd0)  begin fails++; $display("FAIL async_ex got %h exp 0", ex_vec); end
    tests++; if (mem_vec !== 21'd0) begin fails++; $display("FAIL async_mem got %h exp 0", mem_vec); end
    tests++; if (wb_vec !== 21'd0)  begin fails++; $display("FAIL async_wb got %h exp 0", wb_vec); end
    #1 rst = 1'b0;
    tick();
    tests++; if (ex_vec !== {OP_AND, SEL_LOGIC, 16'h0033, 16'h000F, 4'd2, 1'b1}) begin
      fails++; $display("FAIL async_recapture_ex got %h", ex_vec); end
    tests++; if (mem_vec !== 21'd0) begin fails++; $display("FAIL async_discard_mem got %h exp 0", mem_vec); end
    chain = 1'b0;
  endtask

  task automatic test_independence();
    chain = 1'b0;
    id_aluop = 8'h11; id_alusel = 3'd5; id_reg1 = 16'h1234; id_reg2 = 16'h5678;
    id_wd = 4'd7; id_wreg = 1'b1;
    drv_ex_wd = 4'd3; drv_ex_wreg = 1'b0; drv_ex_wdata = 16'hBEEF;
    drv_mem_wd = 4'd9; drv_mem_wreg = 1'b1; drv_mem_wdata = 16'h0000;
    tick();
    tick();
    drv_mem_wdata = 16'hA5A5;
    tick();
    tests++; if (wb_vec !== {4'd9, 1'b1, 16'hA5A5}) begin
      fails++; $display("FAIL indep_wb got %h exp %h", wb_vec, {4'd9, 1'b1, 16'hA5A5}); end
    tests++; if (mem_vec !== {4'd3, 1'b0, 16'hBEEF}) begin
      fails++; $display("FAIL indep_mem got %h exp %h", mem_vec, {4'd3, 1'b0, 16'hBEEF}); end
    tests++; if (ex_vec !== {8'h11, 3'd5, 16'h1234, 16'h5678, 4'd7, 1'b1}) begin
      fails++; $display("FAIL indep_ex got %h", ex_vec); end
  endtask

  task automatic test_back_to_back();
    chain = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      id_reg1 = 16'(i);
      #4;
      tests++; if (ex_reg1 !== 16'(i - 1) && i > 1) begin
        fails++; $display("FAIL b2b_hold got %0d exp %0d", ex_reg1, i - 1); end
      tick();
      tests++; if (ex_reg1 !== 16'(i)) begin
        fails++; $display("FAIL b2b_seq got %0d exp %0d", ex_reg1, i); end
    end
  endtask

  // Reference: a bank shows, after an edge, whatever its inputs were just before
  // that edge, or zeros if reset was high at the edge or has pulsed since.
  task automatic test_random();
    logic [47:0] exp_ex;
    logic [20:0] exp_mem, exp_wb;
    logic        hold_rst;
    hold_rst = 1'b0;
    chain = 1'b0;
    for (int c = 0; c < 300; c++) begin
      id_aluop = 8'($urandom); id_alusel = 3'($urandom);
      id_reg1 = 16'($urandom); id_reg2 = 16'($urandom);
      id_wd = 4'($urandom); id_wreg = 1'($urandom);
      drv_ex_wd = 4'($urandom); drv_ex_wreg = 1'($urandom); drv_ex_wdata = 16'($urandom);
      drv_mem_wd = 4'($urandom); drv_mem_wreg = 1'($urandom); drv_mem_wdata = 16'($urandom);
      if (hold_rst) begin
        #2 rst = 1'b0;
        hold_rst = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        #2 rst = 1'b1;
        #1;
        tests++; if ({ex_vec, mem_vec, wb_vec} !== 90'd0) begin
          fails++; $display("FAIL rand_async c=%0d got %h %h %h", c, ex_vec, mem_vec, wb_vec); end
        #1 rst = 1'b0;
      end
      #1;
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        hold_rst = 1'b1;
      end
      exp_ex  = hold_rst ? 48'd0 : id_vec;
      exp_mem = hold_rst ? 21'd0 : exres_vec;
      exp_wb  = hold_rst ? 21'd0 : memres_vec;
      tick();
      tests++; if (ex_vec !== exp_ex) begin
        fails++; $display("FAIL rand_ex c=%0d got %h exp %h", c, ex_vec, exp_ex); end
      tests++; if (mem_vec !== exp_mem) begin
        fails++; $display("FAIL rand_mem c=%0d got %h exp %h", c, mem_vec, exp_mem); end
      tests++; if (wb_vec !== exp_wb) begin
        fails++; $display("FAIL rand_wb c=%0d got %h exp %h", c, wb_vec, exp_wb); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_latency();
    test_chain();
    test_async_reset();
    test_independence();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
